keypad_code_entry: RTL and testbench

- Keypad front end that drives the 4-bit keypad command bus of the alarm controller.
- Collects key events: a command key (ARM/DISARM), a 4-digit PIN, then ENTER. On a PIN match it holds the arm code 4'b0011 or the disarm code 4'b1100 on the bus for a fixed number of enabled cycles.
- Counts consecutive wrong PINs and locks the keypad out after too many failures.
- Shares clk and the ENA clock-enable with the alarm controller.

---
 rtl/keypad_code_entry.sv | 181 ++++++++++++++++++
 tb/tb_keypad_code_entry.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_entry.sv
// Keypad front end: collects a command key, a 4-digit PIN and ENTER, then drives
// the alarm command bus. Tracks consecutive wrong PINs and locks out after too many.
module keypad_code_entry #(
  parameter logic [15:0] PIN            = 16'h1234,
  parameter int          CMD_HOLD       = 4,
  parameter int          ENTRY_TIMEOUT  = 100,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] keypad_out,
  output logic       busy,
  output logic       pin_error,
  output logic       locked
);

  localparam int HOLD_W  = $clog2(CMD_HOLD + 1);
  localparam int ENTRY_W = $clog2(ENTRY_TIMEOUT + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(CMD_HOLD);
  localparam logic [ENTRY_W-1:0] ENTRY_LOAD = ENTRY_W'(ENTRY_TIMEOUT);
  localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCKOUT_CYCLES);

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  localparam logic [3:0] KEY_ARM     = 4'hC;
  localparam logic [3:0] KEY_DISARM  = 4'hD;
  localparam logic [3:0] CODE_IDLE   = 4'b0000;
  localparam logic [3:0] CODE_ARM    = 4'b0011;
  localparam logic [3:0] CODE_DISARM = 4'b1100;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND, LOCKOUT} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        buf_reg, buf_next;
  logic [2:0]         count_reg, count_next;
  logic               arm_reg, arm_next;
  logic [FAIL_W-1:0]  fail_reg, fail_next;
  logic [ENTRY_W-1:0] entry_reg, entry_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [LOCK_W-1:0]  lock_reg, lock_next;
  logic [3:0]         out_reg, out_next;
  logic               err_reg, err_next;
  logic               busy_reg, locked_reg;

  logic              is_digit, is_cmd, is_clear, is_enter;
  logic [FAIL_W-1:0] fail_inc;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_cmd   = key_valid && ((key_code == KEY_ARM) || (key_code == KEY_DISARM));
  assign is_clear = key_valid && (key_code == KEY_CLEAR);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign fail_inc = fail_reg + FAIL_W'(1);

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    count_next = count_reg;
    arm_next   = arm_reg;
    fail_next  = fail_reg;
    entry_next = entry_reg;
    hold_next  = hold_reg;
    lock_next  = lock_reg;
    out_next   = out_reg;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (is_cmd) begin
          state_next = COLLECT;
          arm_next   = (key_code == KEY_ARM);
          buf_next   = '0;
          count_next = '0;
          entry_next = ENTRY_LOAD;
        end
      end

      COLLECT: begin
        if (is_digit) begin
          buf_next   = {buf_reg[11:0], key_code};
          // count of 5 marks an overlong entry, which can never match
          count_next = (count_reg == 3'd5) ? 3'd5 : count_reg + 3'd1;
          entry_next = ENTRY_LOAD;
        end else if (is_cmd) begin
          arm_next   = (key_code == KEY_ARM);
          buf_next   = '0;
          count_next = '0;
          entry_next = ENTRY_LOAD;
        end else if (is_clear) begin
          state_next = IDLE;
        end else if (is_enter) begin
          if ((count_reg == 3'd4) && (buf_reg == PIN)) begin
            state_next = SEND;
            out_next   = arm_reg ? CODE_ARM : CODE_DISARM;
            fail_next  = '0;
            hold_next  = HOLD_LOAD;
          end else begin
            err_next  = 1'b1;
            fail_next = fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state_next = LOCKOUT;
              lock_next  = LOCK_LOAD;
            end else begin
              state_next = IDLE;
            end
          end
        end else if (entry_reg <= ENTRY_W'(1)) begin
          state_next = IDLE;
          entry_next = '0;
        end else begin
          entry_next = entry_reg - ENTRY_W'(1);
        end
      end

      SEND: begin
        if (hold_reg <= HOLD_W'(1)) begin
          state_next = IDLE;
          out_next   = CODE_IDLE;
          hold_next  = '0;
        end else begin
          hold_next = hold_reg - HOLD_W'(1);
        end
      end

      LOCKOUT: begin
        if (lock_reg <= LOCK_W'(1)) begin
          state_next = IDLE;
          fail_next  = '0;
          lock_next  = '0;
        end else begin
          lock_next = lock_reg - LOCK_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      buf_reg    <= '0;
      count_reg  <= '0;
      arm_reg    <= 1'b0;
      fail_reg   <= '0;
      entry_reg  <= '0;
      hold_reg   <= '0;
      lock_reg   <= '0;
      out_reg    <= CODE_IDLE;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      locked_reg <= 1'b0;
    end else if (ENA) begin
      state_reg  <= state_next;
      buf_reg    <= buf_next;
      count_reg  <= count_next;
      arm_reg    <= arm_next;
      fail_reg   <= fail_next;
      entry_reg  <= entry_next;
      hold_reg   <= hold_next;
      lock_reg   <= lock_next;
      out_reg    <= out_next;
      err_reg    <= err_next;
      busy_reg   <= (state_next == COLLECT) || (state_next == SEND);
      locked_reg <= (state_next == LOCKOUT);
    end
  end

  assign keypad_out = out_reg;
  assign busy       = busy_reg;
  assign pin_error  = err_reg;
  assign locked     = locked_reg;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench for keypad_code_entry: vector table plus hand-written
// sequences for timeout, lockout, ENA gating and asynchronous reset.
module tb_keypad_code_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ENA = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] keypad_out;
  logic       busy, pin_error, locked;

  keypad_code_entry dut (
    .clk       (clk),
    .reset     (reset),
    .ENA       (ENA),
    .key_valid (key_valid),
    .key_code  (key_code),
    .keypad_out(keypad_out),
    .busy      (busy),
    .pin_error (pin_error),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] KA = 4'hA, KB = 4'hB, KC = 4'hC, KD = 4'hD;

  typedef struct packed {
    logic [3:0] out;
    logic       busy;
    logic       err;
    logic       lock;
  } exp_t;

  typedef struct packed {
    logic ena;
    logic kv;
    logic [3:0] key;
    exp_t exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  function automatic exp_t E(logic [3:0] o, logic b, logic e, logic l);
    exp_t r;
    r.out = o; r.busy = b; r.err = e; r.lock = l;
    return r;
  endfunction

  task automatic check(string name, exp_t e);
    exp_t a;
    a = {keypad_out, busy, pin_error, locked};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got out=%b busy=%b err=%b lock=%b, expected out=%b busy=%b err=%b lock=%b",
               name, a.out, a.busy, a.err, a.lock, e.out, e.busy, e.err, e.lock);
    end
  endtask

  task automatic cyc(string name, logic ena, logic kv, logic [3:0] key, exp_t e);
    ENA = ena; key_valid = kv; key_code = key;
    sb.push_back(e);
    @(posedge clk); #1;
    check(name, sb.pop_front());
  endtask

  task automatic add(logic ena, logic kv, logic [3:0] key, exp_t e);
    vec_t v;
    v.ena = ena; v.kv = kv; v.key = key; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0; ENA = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    @(posedge clk); #1;
    check("reset", E(4'h0, 0, 0, 0));
    reset = 1'b1;
  endtask

  // Full correct entry; keypad_out holds the code on the ENTER edge plus three more.
  task automatic arm(string tag, logic [3:0] cmd, logic [3:0] code);
    logic [3:0] digits [4];
    digits = '{4'h1, 4'h2, 4'h3, 4'h4};
    cyc({tag, "_cmd"}, 1, 1, cmd, E(4'h0, 1, 0, 0));
    for (int i = 0; i < 4; i++) cyc({tag, "_dig"}, 1, 1, digits[i], E(4'h0, 1, 0, 0));
    cyc({tag, "_enter"}, 1, 1, KB, E(code, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc({tag, "_hold"}, 1, 0, 4'h0, E(code, 1, 0, 0));
    cyc({tag, "_done"}, 1, 0, 4'h0, E(4'h0, 0, 0, 0));
  endtask

  initial begin
    logic [3:0] pin_keys [6];
    pin_keys = '{KC, 4'h1, 4'h2, 4'h3, 4'h4, KB};

    // Arm, disarm, then an overlong PIN
    add(1, 1, KC, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h1, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h2, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h3, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h4, E(4'h0, 1, 0, 0));
    add(1, 1, KB, E(4'h3, 1, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 0, 4'h0, E(4'h3, 1, 0, 0));
    add(1, 0, 4'h0, E(4'h0, 0, 0, 0));
    add(1, 1, KD, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h1, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h2, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h3, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h4, E(4'h0, 1, 0, 0));
    add(1, 1, KB, E(4'hC, 1, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 0, 4'h0, E(4'hC, 1, 0, 0));
    add(1, 0, 4'h0, E(4'h0, 0, 0, 0));
    add(1, 1, KD, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h1, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h2, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h3, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h4, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h5, E(4'h0, 1, 0, 0));
    add(1, 1, KB, E(4'h0, 0, 1, 0));
    add(1, 0, 4'h0, E(4'h0, 0, 0, 0));
    // CLEAR abandons the entry; the later ENTER is ignored in IDLE
    add(1, 1, KC, E(4'h0, 1, 0, 0));
    add(1, 1, 4'h1, E(4'h0, 1, 0, 0));
    add(1, 1, KA, E(4'h0, 0, 0, 0));
    add(1, 1, KB, E(4'h0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("tbl[%0d]", i), tbl[i].ena, tbl[i].kv, tbl[i].key, tbl[i].exp);

    // Three wrong PINs lead to lockout; keys during lockout are ignored
    do_reset();
    for (int f = 0; f < 3; f++) begin
      cyc("bad_cmd", 1, 1, KC, E(4'h0, 1, 0, 0));
      for (int d = 0; d < 4; d++) cyc("bad_dig", 1, 1, 4'h9, E(4'h0, 1, 0, 0));
      cyc($sformatf("bad_enter%0d", f), 1, 1, KB, E(4'h0, 0, 1, (f == 2)));
      if (f < 2) cyc("bad_idle", 1, 0, 4'h0, E(4'h0, 0, 0, 0));
    end
    for (int i = 1; i < 50; i++) begin
      if (i >= 10 && i < 16)
        cyc($sformatf("lock_key%0d", i), 1, 1, pin_keys[i-10], E(4'h0, 0, 0, 1));
      else
        cyc($sformatf("lock%0d", i), 1, 0, 4'h0, E(4'h0, 0, 0, 1));
    end
    cyc("lock_end", 1, 0, 4'h0, E(4'h0, 0, 0, 0));
    arm("post_lock", KC, 4'h3);

    // Entry timeout after 100 idle enabled cycles
    do_reset();
    cyc("to_cmd", 1, 1, KC, E(4'h0, 1, 0, 0));
    cyc("to_d1", 1, 1, 4'h1, E(4'h0, 1, 0, 0));
    cyc("to_d2", 1, 1, 4'h2, E(4'h0, 1, 0, 0));
    for (int i = 1; i < 100; i++) begin
      ENA = 1'b1; key_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("to_wait99", E(4'h0, 1, 0, 0));
    cyc("to_expire", 1, 0, 4'h0, E(4'h0, 0, 0, 0));
    cyc("to_d3", 1, 1, 4'h3, E(4'h0, 0, 0, 0));
    cyc("to_d4", 1, 1, 4'h4, E(4'h0, 0, 0, 0));
    cyc("to_enter", 1, 1, KB, E(4'h0, 0, 0, 0));
    cyc("to_after", 1, 0, 4'h0, E(4'h0, 0, 0, 0));

    // ENA toggling; keys shown on ENA=0 cycles must be lost
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc($sformatf("ena_key%0d", k), 1, 1, pin_keys[k], E((k == 5) ? 4'h3 : 4'h0, 1, 0, 0));
      cyc($sformatf("ena_gap%0d", k), 0, 1, 4'h9, E((k == 5) ? 4'h3 : 4'h0, 1, 0, 0));
    end
    for (int j = 1; j <= 4; j++) begin
      cyc($sformatf("ena_hold%0d", j), 1, 0, 4'h0, E((j < 4) ? 4'h3 : 4'h0, (j < 4), 0, 0));
      if (j < 4) cyc($sformatf("ena_hgap%0d", j), 0, 0, 4'h0, E(4'h3, 1, 0, 0));
    end
    cyc("ena_lost_cmd", 0, 1, KC, E(4'h0, 0, 0, 0));
    cyc("ena_lost_chk", 1, 0, 4'h0, E(4'h0, 0, 0, 0));

    // Asynchronous reset two cycles into SEND
    do_reset();
    cyc("ar_cmd", 1, 1, KC, E(4'h0, 1, 0, 0));
    for (int d = 1; d < 5; d++) cyc("ar_dig", 1, 1, pin_keys[d], E(4'h0, 1, 0, 0));
    cyc("ar_enter", 1, 1, KB, E(4'h3, 1, 0, 0));
    cyc("ar_hold1", 1, 0, 4'h0, E(4'h3, 1, 0, 0));
    cyc("ar_hold2", 1, 0, 4'h0, E(4'h3, 1, 0, 0));
    reset = 1'b0;
    #1;
    check("async_reset", E(4'h0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    arm("post_reset", KC, 4'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
